// File: rtl/ejercicio_11.sv
// Period meter: rising-edge to rising-edge time of a slow async input,
// reported in PRESCALE-cycle units, saturating at 2^WIDTH-1.
//
// Ports:
//   clock      system clock, all logic on its rising edge
//   reset      synchronous, active-high
//   i_signal   asynchronous input to be measured
//   o_periodo  last measured period (registered, held between updates)
module ejercicio_11 #(
  parameter int PRESCALE = 500,
  parameter int WIDTH    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_signal,
  output logic [WIDTH-1:0] o_periodo
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]    PRE_ONE  = PW'(1);
  localparam logic [PW-1:0]    PRE_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;

  logic             s1_q, s2_q, s3_q;
  logic [PW-1:0]    pre_q, pre_d;
  logic [WIDTH-1:0] per_q, per_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             armed_q, armed_d;

  logic rise;
  logic tick;

  assign rise = s2_q & ~s3_q;
  assign tick = (pre_q == PRE_LAST);

  // The rise edge itself is the first clock of the new interval, so the
  // prescaler restarts at 1. That way a spacing of exactly k*PRESCALE
  // clocks has completed k units when the next rise is captured, and a
  // tick landing on that rise belongs to the following unit (discarded).
  always_comb begin
    pre_d   = pre_q;
    per_d   = per_q;
    out_d   = out_q;
    armed_d = armed_q;
    if (rise) begin
      if (armed_q) begin
        out_d = per_q;
      end
      pre_d   = PRE_ONE;
      per_d   = CNT_ZERO;
      armed_d = 1'b1;
    end else if (tick) begin
      pre_d = PRE_ZERO;
      if (per_q != CNT_MAX) begin
        per_d = per_q + WIDTH'(1);
      end
    end else begin
      pre_d = pre_q + PW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      pre_q   <= PRE_ZERO;
      per_q   <= CNT_ZERO;
      out_q   <= CNT_ZERO;
      armed_q <= 1'b0;
    end else begin
      s1_q    <= i_signal;
      s2_q    <= s1_q;
      s3_q    <= s2_q;
      pre_q   <= pre_d;
      per_q   <= per_d;
      out_q   <= out_d;
      armed_q <= armed_d;
    end
  end

  assign o_periodo = out_q;

endmodule

// File: tb/tb_ejercicio_11.sv
// Bench for ejercicio_11: directed periods plus random spacings checked
// against min(floor(N/PRESCALE), 255) with first-rise arming.
module tb_ejercicio_11;

  localparam int P = 5;

  logic       clock = 1'b0;
  logic       reset;
  logic       i_signal;
  logic [7:0] o_periodo;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] exp_v = 8'd0;
  bit   armed = 1'b0;
  int   last_p = 0;

  always #20 clock = ~clock;

  ejercicio_11 #(
    .PRESCALE(P),
    .WIDTH(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .i_signal(i_signal),
    .o_periodo(o_periodo)
  );

  function automatic logic [7:0] ref_period(int n);
    int u;
    u = n / P;
    return (u > 255) ? 8'd255 : 8'(u);
  endfunction

  task automatic check(input string tag, input logic [7:0] e);
    n_checks++;
    assert (o_periodo === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, o_periodo, e);
    end
  endtask

  // One input period of p clocks starting with a rise; checked at its end.
  task automatic period(input int p, input string tag);
    i_signal = 1'b1;
    if (armed) exp_v = ref_period(last_p);
    armed  = 1'b1;
    last_p = p;
    repeat (p / 2) @(negedge clock);
    i_signal = 1'b0;
    repeat (p - p / 2) @(negedge clock);
    check(tag, exp_v);
  endtask

  initial begin
    #10ms;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int p;
    reset    = 1'b1;
    i_signal = 1'b0;
    repeat (3) @(negedge clock);
    check("reset", 8'd0);
    reset = 1'b0;
    repeat (200) @(negedge clock);
    check("idle", 8'd0);

    period(500, "arm_only");
    period(500, "p500_a");
    period(500, "p500_b");
    period(200, "p500_c");
    period(502, "p200");
    period(5, "p502_floor");
    period(2000, "p5_one");
    period(500, "p2000_dummy");
    check("sat_255", 8'd255);
    period(250, "p500_after_sat");
    period(500, "p250_half");
    period(4, "p500_again");
    period(500, "p4_zero");

    i_signal = 1'b1;
    if (armed) exp_v = ref_period(last_p);
    armed = 1'b1;
    repeat (150) @(negedge clock);
    i_signal = 1'b0;
    repeat (150) @(negedge clock);
    check("pre_reset", exp_v);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    exp_v = 8'd0;
    armed = 1'b0;
    check("mid_reset", 8'd0);
    repeat (100) @(negedge clock);
    period(500, "rearm_only");
    period(500, "after_reset");
    period(500, "after_reset_100");

    for (int i = 0; i < 20; i++) begin
      p = $urandom_range(4, 1600);
      period(p, "rand");
    end
    period(500, "rand_last");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
